// File: rtl/twoof5_pkg.sv
// Shared definitions for the 2-out-of-5 receiver and its companion blocks:
// bit weights, digit codewords (a is the MSB), FSM states and a popcount helper.
package twoof5_pkg;

  localparam int unsigned WEIGHT_A = 1;
  localparam int unsigned WEIGHT_B = 2;
  localparam int unsigned WEIGHT_C = 4;
  localparam int unsigned WEIGHT_D = 7;
  localparam int unsigned WEIGHT_E = 0;

  localparam logic [4:0] CW_0 = 5'b00110;
  localparam logic [4:0] CW_1 = 5'b10001;
  localparam logic [4:0] CW_2 = 5'b01001;
  localparam logic [4:0] CW_3 = 5'b11000;
  localparam logic [4:0] CW_4 = 5'b00101;
  localparam logic [4:0] CW_5 = 5'b10100;
  localparam logic [4:0] CW_6 = 5'b01100;
  localparam logic [4:0] CW_7 = 5'b00011;
  localparam logic [4:0] CW_8 = 5'b10010;
  localparam logic [4:0] CW_9 = 5'b01010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  function automatic logic [2:0] popcount5(input logic [4:0] x);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 5; i++) begin
      n = n + {2'b00, x[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/twoof5_check.sv
// Combinational 2-out-of-5 validity check; shared by receiver and transmitter.
module twoof5_check
  import twoof5_pkg::*;
(
  input  logic [4:0] cw,
  output logic       ok
);

  // Valid exactly when two of the five bits are set.
  always_comb begin
    ok = (popcount5(cw) == 3'd2);
  end

endmodule

// File: rtl/twoof5_rx.sv
// Framed serial receiver for 2-out-of-5 digits: start(1), a..e, stop(0),
// with code/framing checks and an inter-strobe timeout.
module twoof5_rx
  import twoof5_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic sdi,
  input  logic sdi_en,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic e,
  output logic v,
  output logic done,
  output logic code_err,
  output logic frame_err
);

  localparam int CNT_W = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  logic [2:0]       r_bitcnt;
  logic [4:0]       r_sr;
  logic [4:0]       r_cw;
  logic [CNT_W-1:0] r_idle;
  logic             r_v;
  logic             r_done;
  logic             r_code_err;
  logic             r_frame_err;
  logic             w_ok;

  twoof5_check u_check (
    .cw (r_sr),
    .ok (w_ok)
  );

  // Frame FSM; the idle counter only runs inside a frame and a strobe always beats expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_bitcnt    <= 3'd0;
      r_sr        <= 5'b00000;
      r_cw        <= 5'b00000;
      r_idle      <= {CNT_W{1'b0}};
      r_v         <= 1'b0;
      r_done      <= 1'b0;
      r_code_err  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if ((r_state != IDLE) && !sdi_en) begin
        if (TO_EN && (r_idle == IDLE_LAST)) begin
          r_state     <= IDLE;
          r_idle      <= {CNT_W{1'b0}};
          r_done      <= 1'b1;
          r_v         <= 1'b0;
          r_code_err  <= 1'b0;
          r_frame_err <= 1'b1;
        end else begin
          r_idle <= r_idle + CNT_W'(1);
        end
      end else begin
        r_idle <= {CNT_W{1'b0}};
        case (r_state)
          IDLE: begin
            if (sdi_en && sdi) begin
              r_state  <= DATA;
              r_bitcnt <= 3'd0;
            end else begin
              r_state <= IDLE;
            end
          end
          DATA: begin
            r_sr     <= {r_sr[3:0], sdi};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd4) begin
              r_state <= STOP;
            end else begin
              r_state <= DATA;
            end
          end
          STOP: begin
            r_state     <= IDLE;
            r_done      <= 1'b1;
            r_frame_err <= sdi;
            r_code_err  <= !w_ok;
            if (!sdi && w_ok) begin
              r_cw <= r_sr;
              r_v  <= 1'b1;
            end else begin
              r_v  <= 1'b0;
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign a         = r_cw[4];
  assign b         = r_cw[3];
  assign c         = r_cw[2];
  assign d         = r_cw[1];
  assign e         = r_cw[0];
  assign v         = r_v;
  assign done      = r_done;
  assign code_err  = r_code_err;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_twoof5_rx.sv
// Self-checking bench: frame-level reference model compared every cycle,
// plus hand-computed checkpoints for the directed scenarios.
module tb_twoof5_rx;
  import twoof5_pkg::*;

  localparam int TOUT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sdi = 1'b0;
  logic sdi_en = 1'b0;
  logic a, b, c, d, e, v, done, code_err, frame_err;

  int n_tests = 0;
  int n_fail  = 0;

  twoof5_rx #(.TIMEOUT(TOUT)) dut (
    .clk(clk), .rst(rst), .sdi(sdi), .sdi_en(sdi_en),
    .a(a), .b(b), .c(c), .d(d), .e(e), .v(v),
    .done(done), .code_err(code_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Reference model: collects data bits of a frame and applies the frame rules.
  logic       m_in = 1'b0;
  int         m_n = 0;
  int         m_gap = 0;
  logic       m_bits [0:4];
  logic [4:0] m_cw = 5'b00000;
  logic       m_v = 1'b0, m_done = 1'b0, m_ce = 1'b0, m_fe = 1'b0;
  logic [4:0] m_word;
  logic       m_two;

  assign m_word = {m_bits[0], m_bits[1], m_bits[2], m_bits[3], m_bits[4]};
  assign m_two  = ($countones(m_word) == 2);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_in <= 1'b0; m_n <= 0; m_gap <= 0; m_cw <= 5'b00000;
      m_v <= 1'b0; m_done <= 1'b0; m_ce <= 1'b0; m_fe <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (sdi_en) begin
        m_gap <= 0;
        if (!m_in) begin
          if (sdi) begin
            m_in <= 1'b1;
            m_n  <= 0;
          end
        end else if (m_n < 5) begin
          m_bits[m_n] <= sdi;
          m_n <= m_n + 1;
        end else begin
          m_in   <= 1'b0;
          m_done <= 1'b1;
          m_fe   <= sdi;
          m_ce   <= !m_two;
          if (!sdi && m_two) begin
            m_cw <= m_word;
            m_v  <= 1'b1;
          end else begin
            m_v <= 1'b0;
          end
        end
      end else if (m_in) begin
        if (m_gap + 1 == TOUT) begin
          m_in <= 1'b0; m_done <= 1'b1; m_v <= 1'b0; m_fe <= 1'b1; m_ce <= 1'b0;
          m_gap <= 0;
        end else begin
          m_gap <= m_gap + 1;
        end
      end
    end
  end

  wire [8:0] outs  = {a, b, c, d, e, v, done, code_err, frame_err};
  wire [8:0] m_exp = {m_cw, m_v, m_done, m_ce, m_fe};

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    n_tests++;
    if (outs !== m_exp) begin
      n_fail++;
      $display("FAIL model_cmp t=%0t got=%b expected=%b", $time, outs, m_exp);
    end
  end

  task automatic chk(input string nm, input logic [8:0] exp);
    n_tests++;
    if (outs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b expected=%b", nm, outs, exp);
    end
  endtask

  task automatic cyc(input logic en, input logic dv);
    @(posedge clk);
    #1;
    sdi_en = en;
    sdi    = dv;
  endtask

  task automatic strobe(input logic dv, input int gap);
    repeat (gap) cyc(1'b0, 1'b0);
    cyc(1'b1, dv);
  endtask

  task automatic send_frame(input logic [4:0] data, input logic sp, input int gap);
    logic [4:0] dd;
    dd = data;
    strobe(1'b1, gap);
    for (int i = 4; i >= 0; i--) strobe(dd[i], gap);
    strobe(sp, gap);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 9'b000000000);
    rst = 1'b0;

    // Digit 5: loaded, v=1, done pulse for one cycle.
    send_frame(CW_5, 1'b0, 0);
    cyc(1'b0, 1'b0);
    chk("digit5_done", 9'b101001100);
    cyc(1'b0, 1'b0);
    chk("digit5_done_clear", 9'b101001000);

    // Three ones: code error, outputs hold.
    send_frame(5'b11100, 1'b0, 1);
    cyc(1'b0, 1'b0);
    chk("popcount3", 9'b101000110);

    // Valid data, bad stop bit.
    send_frame(CW_7, 1'b1, 0);
    cyc(1'b0, 1'b0);
    chk("bad_stop", 9'b101000101);

    // All zeros is a code error.
    send_frame(5'b00000, 1'b0, 0);
    cyc(1'b0, 1'b0);
    chk("zero_word", 9'b101000110);

    // Timeout: start + 2 data bits, then silence; abort lands 8 cycles after last strobe.
    strobe(1'b1, 0);
    strobe(1'b0, 0);
    strobe(1'b1, 0);
    for (int j = 1; j <= 9; j++) begin
      cyc(1'b0, 1'b0);
      if (j == 8) chk("timeout_not_yet", 9'b101000010);
    end
    chk("timeout_abort", 9'b101000101);
    send_frame(CW_0, 1'b0, 0);
    cyc(1'b0, 1'b0);
    chk("digit0_after_timeout", 9'b001101100);

    // Strobes exactly at the expiry cycle win.
    send_frame(CW_3, 1'b0, TOUT - 1);
    cyc(1'b0, 1'b0);
    chk("coincident_strobe", 9'b110001100);

    // Back-to-back frames with the strobe held high throughout.
    send_frame(CW_8, 1'b0, 0);
    send_frame(CW_7, 1'b0, 0);
    cyc(1'b0, 1'b0);
    chk("back_to_back", 9'b000111100);

    // Reset after the third data bit clears outputs asynchronously.
    strobe(1'b1, 0);
    strobe(1'b0, 0);
    strobe(1'b1, 0);
    strobe(1'b0, 0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    sdi_en = 1'b0;
    #1;
    chk("async_reset", 9'b000000000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b0, 1'b0);
    chk("after_reset_no_done", 9'b000000000);
    send_frame(CW_9, 1'b0, 0);
    cyc(1'b0, 1'b0);
    chk("digit9_after_reset", 9'b010101100);

    repeat (3) cyc(1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
